mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256x16 RAM.
- Shares the RAM between the CPU controller/datapath ("cpu" port) and an external I/O or loader agent ("io" port).
- Round-robin grant, programmable access wait states, one-cycle completion pulse per requester.
- Sits between the requesters and the RAM. Drives the RAM's rw/address/write-data lines and captures its read data.

Parameters:
- AW, 8, address width.
- DW, 16, data width.
- ACC_CYC, 1, number of cycles the RAM lines are held per access. Must be >= 1; 0 is illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- cpu_req  in  1  cpu request, level, held until cpu_done
- cpu_rw  in  1  1=write, 0=read
- cpu_addr  in  AW  cpu address
- cpu_wdata  in  DW  cpu write data
- cpu_gnt  out  1  high while cpu owns RAM (ACCESS and DONE)
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid when cpu_done=1, held until next cpu completion
- io_req/io_rw/io_addr/io_wdata/io_gnt/io_done/io_rdata  same as cpu_* for the io requester
- mem_rw  out  1  to RAM, 1=write
- mem_addr  out  AW  to RAM
- mem_d  out  DW  write data to RAM
- mem_q  in  DW  RAM read data, combinational from mem_addr

Behaviour:
- Reset (rst=0 sampled at clk edge):
  - state=IDLE, last_gnt=IO (so cpu wins the first tie).
  - All outputs 0, including both rdata registers.
  - All outputs are registered or decoded from registers only.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No req: stay IDLE; mem_rw=0, mem_addr=0, mem_d=0.
  - One req: grant it.
  - Both req: grant the requester that is not last_gnt.
  - On grant: latch winner's rw/addr/wdata, set owner and last_gnt, load wait counter with ACC_CYC-1, go to ACCESS.
- ACCESS:
  - mem_rw/mem_addr/mem_d driven from the latched copies for exactly ACC_CYC cycles.
  - Requester input changes during ACCESS have no effect.
  - Last ACCESS cycle:
    - Read: mem_q captured into the owner's rdata register.
    - Write: owner's rdata is unchanged.
    - Either way, go to DONE.
- DONE (1 cycle):
  - Owner's done=1; mem_rw=0.
  - All req inputs ignored.
  - Requester must drop req at the edge where it samples done=1.
  - Next state is IDLE.
- gnt: owner's gnt high from first ACCESS cycle through DONE inclusive; never both high.
- Latency: req sampled in IDLE at cycle 0 -> ACCESS cycles 1..ACC_CYC -> done at cycle ACC_CYC+1.
- Loser of a tie: back in IDLE at cycle ACC_CYC+2, granted there, done at 2*ACC_CYC+3.
- Fairness:
  - Alternation under continuous contention.
  - A lone requester is granted every time regardless of last_gnt.
- Reset mid-operation:
  - Transaction aborted; no done pulse.
  - mem_rw=0 from the cycle after rst is sampled low.
  - A partially held write may have occurred; no retry.
- Address/data: no arithmetic; widths pass through unchanged. No wrap-around handling needed beyond AW.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_cnt (16, out) and stat_io_cnt (16, out).
  - Each counts completed transactions (increments in DONE for the owner).
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- cpu write: ACC_CYC=1, cpu_req=1, rw=1, addr=8'h10, wdata=16'hBEEF -> mem_rw=1, mem_addr=8'h10, mem_d=16'hBEEF in cycle 1; cpu_done=1 in cycle 2; RAM[8'h10]=16'hBEEF.
- io read: io read of 8'h10 -> io_rdata=16'hBEEF when io_done=1; cpu_rdata unchanged.
- Tie after reset: cpu_req=io_req=1 in the same cycle -> cpu granted first (cpu_done at cycle 2), io_done at cycle 5; continuous contention thereafter alternates io, cpu, io.
- Wait states: ACC_CYC=3, cpu read of 8'h05 -> mem_addr=8'h05 for cycles 1-3, cpu_done at cycle 4; changing cpu_addr to 8'h06 in cycle 2 has no effect.
- Reset mid-access: rst=0 during a write ACCESS cycle -> next cycle mem_rw=0, gnt=0, no done pulse; after release, a new request is served normally.
- Stats (MEM_ARBITER_STATS_EN): 3 cpu + 2 io transactions -> stat_cpu_cnt=3, stat_io_cnt=2; 65537 cpu transactions -> stat_cpu_cnt=16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port RAM.
// Optional transaction counters enabled by MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int ACC_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_rw,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_done,
    output logic [DW-1:0] io_rdata,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]   stat_cpu_cnt,
    output logic [15:0]   stat_io_cnt
`endif
);

    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_io;
    logic          r_own_io;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_io_rdata;
    logic [CW-1:0] r_cnt;

    logic          w_any_req;
    logic          w_pick_io;
    logic          w_last;
    logic          w_acc;
    logic          w_done;
    logic          w_busy;

    // Arbitration decision: io wins alone, or on a tie when cpu went last
    always_comb begin
        w_any_req = cpu_req | io_req;
        w_pick_io = io_req & (~cpu_req | ~r_last_io);
        w_last    = (r_cnt == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: if (w_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Grant latching, wait counter and read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_io   <= 1'b1;
            r_own_io    <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any_req) begin
                r_own_io  <= w_pick_io;
                r_last_io <= w_pick_io;
                r_rw      <= w_pick_io ? io_rw : cpu_rw;
                r_addr    <= w_pick_io ? io_addr : cpu_addr;
                r_wdata   <= w_pick_io ? io_wdata : cpu_wdata;
                r_cnt     <= CW'(ACC_CYC - 1);
            end
        end else if (r_state == S_ACCESS) begin
            if (!w_last) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (!r_rw) begin
                if (r_own_io) r_io_rdata <= mem_q;
                else          r_cpu_rdata <= mem_q;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        w_acc     = (r_state == S_ACCESS);
        w_done    = (r_state == S_DONE);
        w_busy    = w_acc | w_done;
        cpu_gnt   = w_busy & ~r_own_io;
        io_gnt    = w_busy & r_own_io;
        cpu_done  = w_done & ~r_own_io;
        io_done   = w_done & r_own_io;
        cpu_rdata = r_cpu_rdata;
        io_rdata  = r_io_rdata;
        mem_rw    = w_acc & r_rw;
        mem_addr  = w_acc ? r_addr : '0;
        mem_d     = w_acc ? r_wdata : '0;
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] r_stat_cpu;
    logic [15:0] r_stat_io;

    // Saturating completed-transaction counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_cpu <= '0;
            r_stat_io  <= '0;
        end else if (w_done) begin
            if (r_own_io) begin
                if (r_stat_io != 16'hFFFF) r_stat_io <= r_stat_io + 16'd1;
            end else begin
                if (r_stat_cpu != 16'hFFFF) r_stat_cpu <= r_stat_cpu + 16'd1;
            end
        end
    end

    assign stat_cpu_cnt = r_stat_cpu;
    assign stat_io_cnt  = r_stat_io;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a transaction-level reference
// model, randomized traffic, contention and a mid-access reset.
module tb_mem_arbiter;

    localparam int ACC = 3;
    localparam int TMO = 4 * (ACC + 2) + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [7:0]  addr [2];
    logic [15:0] wd   [2];
    logic        cpu_gnt, cpu_done, io_gnt, io_done;
    logic [15:0] cpu_rdata, io_rdata;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [15:0] mem_d, mem_q;
    logic [1:0]  done;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] stat_cpu_cnt, stat_io_cnt;
    int          exp_scpu, exp_sio;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16), .ACC_CYC(ACC)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(req[0]), .cpu_rw(rw[0]), .cpu_addr(addr[0]),
        .cpu_wdata(wd[0]), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .io_req(req[1]), .io_rw(rw[1]), .io_addr(addr[1]),
        .io_wdata(wd[1]), .io_gnt(io_gnt), .io_done(io_done),
        .io_rdata(io_rdata),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
`ifdef MEM_ARBITER_STATS_EN
        , .stat_cpu_cnt(stat_cpu_cnt), .stat_io_cnt(stat_io_cnt)
`endif
    );

    assign done = {io_done, cpu_done};

    // Behavioural RAM attached to the arbiter
    logic [15:0] ram [256];
    assign mem_q = ram[mem_addr];
    always @(posedge clk) if (mem_rw) ram[mem_addr] <= mem_d;

    typedef struct {
        bit          io;
        bit          rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          t_done;
    } txn_t;

    txn_t        sbq [$];
    logic [15:0] ref_ram [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idle_at = 0;
    bit          last_io = 1'b1;
    logic [15:0] exp_cpu_rd = '0;
    logic [15:0] exp_io_rd = '0;
    int          wt [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model: one transaction in flight, arbiter free again
    // ACC+2 cycles after a grant; ties go to whoever did not go last.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                sbq.delete();
                last_io    = 1'b1;
                idle_at    = cyc + 1;
                exp_cpu_rd = '0;
                exp_io_rd  = '0;
`ifdef MEM_ARBITER_STATS_EN
                exp_scpu = 0;
                exp_sio  = 0;
`endif
            end else if (cyc >= idle_at && req != 2'b00) begin
                txn_t t;
                int   w;
                if (req == 2'b11) w = last_io ? 0 : 1;
                else              w = req[1] ? 1 : 0;
                t.io     = (w == 1);
                t.rw     = rw[w];
                t.addr   = addr[w];
                t.wdata  = wd[w];
                t.rdata  = ref_ram[addr[w]];
                t.t_done = cyc + ACC + 1;
                if (t.rw) ref_ram[t.addr] = t.wdata;
                last_io = t.io;
                idle_at = cyc + ACC + 2;
                sbq.push_back(t);
            end
            cyc++;
        end
    end

    // Monitor: every cycle compare DUT outputs with the front transaction
    initial begin
        @(posedge clk);
        forever begin
            txn_t f;
            bit   have, in_acc, in_done;
            @(negedge clk);
            have = (sbq.size() != 0);
            if (have) f = sbq[0];
            in_done = have && (cyc == f.t_done);
            in_acc  = have && !in_done;
            if (have) chk("window", 32'(cyc >= f.t_done - ACC), 32'(1));
            chk("cpu_gnt", 32'(cpu_gnt), 32'(have && !f.io));
            chk("io_gnt", 32'(io_gnt), 32'(have && f.io));
            chk("mem_rw", 32'(mem_rw), 32'(in_acc && f.rw));
            chk("mem_addr", 32'(mem_addr), 32'(in_acc ? f.addr : 8'h0));
            chk("mem_d", 32'(mem_d), 32'(in_acc ? f.wdata : 16'h0));
            chk("cpu_done", 32'(cpu_done), 32'(in_done && !f.io));
            chk("io_done", 32'(io_done), 32'(in_done && f.io));
            if (in_done) begin
                if (!f.rw) begin
                    if (f.io) exp_io_rd = f.rdata;
                    else      exp_cpu_rd = f.rdata;
                end
`ifdef MEM_ARBITER_STATS_EN
                if (f.io) exp_sio = (exp_sio < 65535) ? exp_sio + 1 : 65535;
                else exp_scpu = (exp_scpu < 65535) ? exp_scpu + 1 : 65535;
`endif
                void'(sbq.pop_front());
            end
            chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
            chk("io_rdata", 32'(io_rdata), 32'(exp_io_rd));
`ifdef MEM_ARBITER_STATS_EN
            chk("stat_cpu", 32'(stat_cpu_cnt), 32'(exp_scpu));
            chk("stat_io", 32'(stat_io_cnt), 32'(exp_sio));
`endif
        end
    end

    // One negedge of random traffic; pct is the raise probability
    task automatic step(int pct);
        for (int r = 0; r < 2; r++) begin
            if (req[r] && done[r]) begin
                req[r] = 1'b0;
                wt[r]  = 0;
            end else if (req[r]) begin
                wt[r]++;
                if (wt[r] > TMO) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout req%0d cycle %0d: no done", r, cyc);
                    req[r] = 1'b0;
                    wt[r]  = 0;
                end else if ($urandom_range(3) == 0) begin
                    rw[r]   = 1'($urandom_range(1));
                    addr[r] = 8'($urandom_range(15));
                    wd[r]   = 16'($urandom);
                end
            end else if (int'($urandom_range(99)) < pct) begin
                req[r]  = 1'b1;
                wt[r]   = 0;
                rw[r]   = 1'($urandom_range(1));
                addr[r] = 8'($urandom_range(15));
                wd[r]   = 16'($urandom);
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(int r, bit w, logic [7:0] a, logic [15:0] d);
        req[r]  = 1'b1;
        rw[r]   = w;
        addr[r] = a;
        wd[r]   = d;
    endtask

    task automatic wait_done(int r);
        bit seen = 1'b0;
        for (int k = 0; k < TMO && !seen; k++) begin
            @(negedge clk);
            seen = done[r];
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done req%0d cycle %0d: no done", r, cyc);
        end
        req[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (req == 2'b00 && sbq.size() == 0) ok = 1'b1;
            else step(0);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain cycle %0d: traffic did not settle", cyc);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        req = 2'b00;
        wt[0] = 0;
        wt[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'(i * 37 + 5);
            ref_ram[i] = 16'(i * 37 + 5);
        end
        rst = 1'b0;
        req = 2'b00;
        rw  = 2'b00;
        for (int r = 0; r < 2; r++) begin
            addr[r] = '0;
            wd[r]   = '0;
            wt[r]   = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(0, 1'b1, 8'h10, 16'hBEEF);
        wait_done(0);
        issue(1, 1'b0, 8'h10, 16'h0000);
        wait_done(1);
        chk("io_read_beef", 32'(io_rdata), 32'h0000BEEF);

        reset_pulse();
        for (int k = 0; k < 60; k++) step(100);
        drain();
        for (int k = 0; k < 500; k++) step(35);
        drain();

        issue(0, 1'b1, 8'h20, 16'hCAFE);
        hit = 1'b0;
        for (int k = 0; k < TMO && !hit; k++) begin
            @(negedge clk);
            hit = mem_rw;
        end
        chk("abort_seen_write", 32'(hit), 32'(1));
        reset_pulse();
        chk("abort_mem_rw", 32'(mem_rw), 32'(0));
        chk("abort_gnt", 32'(cpu_gnt), 32'(0));
        chk("abort_done", 32'(cpu_done), 32'(0));
        @(negedge clk);
        issue(0, 1'b0, 8'h20, 16'h0000);
        wait_done(0);
        chk("after_abort_read", 32'(cpu_rdata), 32'h0000CAFE);

        for (int k = 0; k < 400; k++) step(60);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
